// File: rtl/uart_rx_core.sv
// 8N1 UART receiver driven by a 16x oversample enable; 2-FF input synchronizer,
// 3-sample mid-bit majority vote, one-cycle valid / framing-error pulses.
module uart_rx_core #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_en,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 valid,
  output logic                 framing_error,
  output logic                 busy
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [TW-1:0] M_LO   = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] M_MID  = TW'(OVERSAMPLE / 2);
  localparam logic [TW-1:0] M_HI   = TW'(OVERSAMPLE / 2 + 1);
  localparam logic [TW-1:0] T_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t                 state_q, state_d;
  logic [TW-1:0]          tick_q, tick_d;
  logic [BW-1:0]          bit_q, bit_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic [DATA_BITS-1:0]   data_q, data_d;
  logic [1:0]             samp_q, samp_d;
  logic                   valid_q, valid_d;
  logic                   ferr_q, ferr_d;
  logic                   armed_q, armed_d;
  logic                   rx_meta_q, rx_s_q;
  logic                   vote;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // Earlier two samples are captured in samp_q; the third is the live rx_s.
  assign vote = maj3(samp_q[1], samp_q[0], rx_s_q);

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    samp_d  = samp_q;
    armed_d = armed_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    if (rx_en) begin
      if (rx_s_q) armed_d = 1'b1;
      if (tick_q == M_LO)  samp_d[1] = rx_s_q;
      if (tick_q == M_MID) samp_d[0] = rx_s_q;
      tick_d = (tick_q == T_LAST) ? '0 : tick_q + 1'b1;
      case (state_q)
        S_IDLE: begin
          // tick_q sits at 0 in IDLE, so the detection tick is tick 0.
          if (!rx_s_q && armed_q) state_d = S_START;
          else                    tick_d  = '0;
        end
        S_START: begin
          if (tick_q == M_HI && vote) begin
            state_d = S_IDLE;
            tick_d  = '0;
          end else if (tick_q == T_LAST) begin
            state_d = S_DATA;
            bit_d   = '0;
          end
        end
        S_DATA: begin
          if (tick_q == M_HI) shift_d = {vote, shift_q[DATA_BITS-1:1]};
          if (tick_q == T_LAST) begin
            if (bit_q == B_LAST) state_d = S_STOP;
            else                 bit_d   = bit_q + 1'b1;
          end
        end
        S_STOP: begin
          if (tick_q == M_HI) begin
            data_d  = shift_q;
            state_d = S_IDLE;
            tick_d  = '0;
            if (vote) begin
              valid_d = 1'b1;
            end else begin
              ferr_d  = 1'b1;
              armed_d = 1'b0;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      tick_q    <= '0;
      bit_q     <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      armed_q   <= 1'b1;
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      tick_q    <= tick_d;
      bit_q     <= bit_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
      armed_q   <= armed_d;
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  always_ff @(posedge clk) begin
    shift_q <= shift_d;
    samp_q  <= samp_d;
  end

  assign data_out      = data_q;
  assign valid         = valid_q;
  assign framing_error = ferr_q;
  assign busy          = (state_q != S_IDLE);

endmodule

// File: doc/uart_rx_core.md
# uart_rx_core

Serial UART receiver that sits directly downstream of the baud rate generator. It consumes a 16x-oversample enable pulse and the raw `rx` pin, and recovers 8N1 frames using 3-sample majority voting at mid-bit. Each received byte is presented on a parallel output with a one-cycle valid pulse, and each stop-bit failure raises a one-cycle framing-error pulse. The block feeds the matrix-multiplication operand loader.

## Interface
- `DATA_BITS`, 8: data bits per frame, sent LSB first.
- `OVERSAMPLE`, 16: `rx_en` pulses per bit period. Must be even and ≥ 8.
- `clk` input 1: board clock. All logic is on its rising edge.
- `rst` input 1: synchronous, active-high reset.
- `rx_en` input 1: one-`clk`-wide enable pulse at 16× the baud rate, from the baud stage. Counters advance only on cycles where `rx_en`=1.
- `rx` input 1: asynchronous serial line. Idles high.
- `data_out` output `DATA_BITS`: last received byte. Held until the next frame completes.
- `valid` output 1: one-`clk` pulse. `data_out` holds a good frame.
- `framing_error` output 1: one-`clk` pulse. Stop bit was sampled low.
- `busy` output 1: high while a frame is in progress (any state other than IDLE).

## Operation
- **Input synchronizer:** `rx` passes through a 2-FF synchronizer, `rx_s`, which resets to 1. All decisions use `rx_s`.
- **Counters:**
  - `tick_cnt`: `$clog2(OVERSAMPLE)` bits, counts 0..`OVERSAMPLE`-1.
  - `bit_cnt`: `$clog2(DATA_BITS)` bits.
  - Both change only when `rx_en`=1.
- **Sample points:** `M-1`, `M`, `M+1`, where `M` = `OVERSAMPLE`/2 (7, 8, 9 at default). The bit value is the majority of the three `rx_s` samples. It is decided on the `rx_en` tick where `tick_cnt`=`M+1`.
- **IDLE:**
  - On an `rx_en` tick with `rx_s`=0 and `armed`=1: go to START and set `tick_cnt`=0. That tick is tick 0 of the start bit.
  - `armed` clears on framing error. It sets on any `rx_en` tick with `rx_s`=1. Reset value is 1.
- **START:**
  - At the decision tick, majority 1 means a false start: return to IDLE with no output pulse.
  - Majority 0: wait until `tick_cnt`=`OVERSAMPLE`-1, then go to DATA with `tick_cnt`=0 and `bit_cnt`=0.
- **DATA:**
  - At the decision tick, shift the majority bit into the MSB of the shift register (right shift, so LSB-first arrival ends aligned).
  - At `tick_cnt`=`OVERSAMPLE`-1: if `bit_cnt`=`DATA_BITS`-1, go to STOP; otherwise increment `bit_cnt`. `tick_cnt` wraps to 0 either way.
- **STOP:** at the decision tick, `data_out` ← shift register, then return to IDLE immediately. There is no wait for the end of the stop bit, so the block can resync to back-to-back frames.
  - Majority 1: `valid`=1 on the next `clk`.
  - Majority 0: `framing_error`=1 on the next `clk` and `armed` clears. The line must be seen high before the next start.
- `rx_en`=0 cycles freeze all state except `valid` and `framing_error`, which self-clear after one cycle.
- **Reset mid-frame:** on the next `clk`, go to IDLE. The partial byte is discarded and no pulse is generated.

## Timing
- Reset values:
  - Outputs: `data_out`=0, `valid`=0, `framing_error`=0, `busy`=0.
  - Internal: state=IDLE, `rx_s`=1, `armed`=1.
- Synchronizer latency is 2 `clk`.
- `valid` or `framing_error` rises 1 `clk` after the stop-bit decision tick. `data_out` changes on the same edge.
- Falling edge on `rx` to `valid`, measured in `rx_en` ticks: 16 (start) + 8×16 (data) + 10 (stop ticks 0..9) = 154 ticks at default, plus sync and register latency.
- `busy` rises on the `clk` after start detection. It falls on the same edge that `valid` or `framing_error` rises, or on the `clk` after a false start.
- `valid` and `framing_error` are mutually exclusive and never high for two consecutive cycles.

## Test plan
- **Basic frame:** `rx_en` tied high, `OVERSAMPLE`=16, 16 `clk` per bit, frame 0xA5 with good stop → `valid` high for exactly 1 cycle, `data_out`=0xA5, `framing_error` never high.
- **False start:** `rx` low for 5 ticks, then high → no `valid` or `framing_error`. `busy` returns to 0 by tick 10. A following 0x3C frame is received correctly.
- **Framing error:** frame 0x81 with stop bit 0, then the line held low for 40 ticks, then a good 0x42 frame → `framing_error` pulses once, `data_out`=0x81. No new start is taken while the line stays low. 0x42 then arrives with `valid`.
- **Back-to-back:** 0x00, 0xFF, 0x55 with no idle gap → three `valid` pulses carrying data 0x00, 0xFF, 0x55 in order.
- **Majority voting:** 0xF0, with `rx` forced to the wrong value for one tick at sample point 8 of every data bit → `data_out`=0xF0 and `valid`=1.
- **Reset mid-frame:** `rst` asserted for 1 `clk` during data bit 3 → all outputs 0 and state IDLE next cycle, with no pulse. A subsequent 0x99 frame is received correctly.
